// File: rtl/regfile_write_scheduler_if.sv
// -----------------------------------------------------------------------------
// regfile_write_scheduler_if
// Bundles the signals between the WB stage, the multi-cycle unit, decode/hazard
// logic and the register-file write scheduler.
//   WB side     : wb_valid, wb_reg, wb_data
//   MC side     : mc_issue, mc_issue_reg, mc_valid, mc_reg, mc_data, mc_ready
//   RF side     : rf_reg_write, rf_write_reg, rf_write_data
//   Hazard side : read_reg1, read_reg2, pend1, pend2, stall_req, issue_conflict
// Modports: master = pipeline/environment side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface regfile_write_scheduler_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  logic        mc_issue;
  logic [4:0]  mc_issue_reg;
  logic        mc_valid;
  logic [4:0]  mc_reg;
  logic [31:0] mc_data;
  logic        mc_ready;

  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic        pend1;
  logic        pend2;
  logic        stall_req;
  logic        issue_conflict;

  modport master (
    output wb_valid, wb_reg, wb_data,
    output mc_issue, mc_issue_reg, mc_valid, mc_reg, mc_data,
    output read_reg1, read_reg2,
    input  mc_ready, rf_reg_write, rf_write_reg, rf_write_data,
    input  pend1, pend2, stall_req, issue_conflict
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  mc_issue, mc_issue_reg, mc_valid, mc_reg, mc_data,
    input  read_reg1, read_reg2,
    output mc_ready, rf_reg_write, rf_write_reg, rf_write_data,
    output pend1, pend2, stall_req, issue_conflict
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_write_scheduler
// Arbitrates the single register-file write port between pipeline writeback
// (always wins) and the multi-cycle unit (valid/ready). Tracks in-flight MC
// destinations in a 32-bit pending scoreboard and raises stall_req when the MC
// unit has waited STARVE_LIMIT consecutive cycles.
// Ports:
//   i_clk    : clock, all state on rising edge
//   i_reset  : synchronous active-high reset
//   io_bus   : slave modport of regfile_write_scheduler_if (WB, MC, RF write
//              port, decode read addresses, pending/stall/conflict flags)
// Parameters:
//   STARVE_LIMIT : consecutive MC wait cycles before stall_req (1..15)
// -----------------------------------------------------------------------------
module regfile_write_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  regfile_write_scheduler_if.slave        io_bus
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic        w_wb_eff;
  logic        w_mc_ready;
  logic        w_mc_wait;
  logic        w_conflict;
  logic [3:0]  w_wait_nxt;
  logic [31:0] w_pending_nxt;

  logic        r_rf_we;
  logic [4:0]  r_rf_reg;
  logic [31:0] r_rf_data;
  logic [31:0] r_pending;
  logic        r_clr_vld;
  logic [4:0]  r_clr_reg;
  logic [3:0]  r_wait_cnt;
  logic        r_stall_req;
  logic        r_issue_conflict;

  // A WB write to r0 is a no-op, so it does not block the MC unit.
  assign w_wb_eff   = io_bus.wb_valid && (io_bus.wb_reg != 5'd0);
  assign w_mc_ready = io_bus.mc_valid && !w_wb_eff && !i_reset;
  assign w_mc_wait  = io_bus.mc_valid && !w_mc_ready;

  assign w_wait_nxt = !w_mc_wait              ? 4'd0 :
                      (r_wait_cnt >= LP_LIMIT) ? LP_LIMIT :
                                                 r_wait_cnt + 4'd1;

  // A clear still scheduled for this edge means the register is in flight,
  // so reissuing to it counts as a conflict too.
  assign w_conflict = io_bus.mc_issue && (io_bus.mc_issue_reg != 5'd0) &&
                      (r_pending[io_bus.mc_issue_reg] ||
                       (r_clr_vld && (r_clr_reg == io_bus.mc_issue_reg)));

  // Clear first, then set: a same-edge issue to the register being retired wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_clr_vld) begin
      w_pending_nxt[r_clr_reg] = 1'b0;
    end
    if (io_bus.mc_issue) begin
      w_pending_nxt[io_bus.mc_issue_reg] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Register-file write port: one cycle of latency from grant to write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rf_we   <= 1'b0;
      r_rf_reg  <= 5'd0;
      r_rf_data <= 32'd0;
    end else if (w_wb_eff) begin
      r_rf_we   <= 1'b1;
      r_rf_reg  <= io_bus.wb_reg;
      r_rf_data <= io_bus.wb_data;
    end else if (w_mc_ready) begin
      r_rf_we   <= (io_bus.mc_reg != 5'd0);
      r_rf_reg  <= io_bus.mc_reg;
      r_rf_data <= io_bus.mc_data;
    end else begin
      r_rf_we   <= 1'b0;
    end
  end

  // Scoreboard. The clear is delayed one cycle so the pending bit drops on the
  // same edge the register file actually takes the MC result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending        <= 32'd0;
      r_clr_vld        <= 1'b0;
      r_clr_reg        <= 5'd0;
      r_issue_conflict <= 1'b0;
    end else begin
      r_pending        <= w_pending_nxt;
      r_clr_vld        <= w_mc_ready;
      r_clr_reg        <= io_bus.mc_reg;
      r_issue_conflict <= w_conflict;
    end
  end

  // Starvation counter; stall_req tracks "counter at limit" as a register so
  // it drops the cycle after the MC grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait_cnt  <= 4'd0;
      r_stall_req <= 1'b0;
    end else begin
      r_wait_cnt  <= w_wait_nxt;
      r_stall_req <= (w_wait_nxt == LP_LIMIT);
    end
  end

  assign io_bus.mc_ready       = w_mc_ready;
  assign io_bus.rf_reg_write   = r_rf_we;
  assign io_bus.rf_write_reg   = r_rf_reg;
  assign io_bus.rf_write_data  = r_rf_data;
  assign io_bus.pend1          = r_pending[io_bus.read_reg1];
  assign io_bus.pend2          = r_pending[io_bus.read_reg2];
  assign io_bus.stall_req      = r_stall_req;
  assign io_bus.issue_conflict = r_issue_conflict;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_scheduler
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model of the write-port arbitration, scoreboard and
// starvation rules.
// -----------------------------------------------------------------------------
module tb_regfile_write_scheduler;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_scheduler_if bus();

  regfile_write_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit [31:0] m_pend;
  int        m_clr_q[$];
  bit        m_rf_we;
  bit [4:0]  m_rf_reg;
  bit [31:0] m_rf_data;
  int        m_wait;
  bit        m_conflict;
  bit        m_known = 1'b0;
  bit        m_last_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus.wb_valid     = 1'b0;
    bus.wb_reg       = 5'd0;
    bus.wb_data      = 32'd0;
    bus.mc_issue     = 1'b0;
    bus.mc_issue_reg = 5'd0;
    bus.mc_valid     = 1'b0;
    bus.mc_reg       = 5'd0;
    bus.mc_data      = 32'd0;
    bus.read_reg1    = 5'd0;
    bus.read_reg2    = 5'd0;
  endtask

  // Called at a falling edge with inputs already driven: checks outputs
  // against the model, advances the model across the next rising edge.
  task automatic tick();
    bit wb_eff, mc_ok, conf, in_clr;
    #1;
    wb_eff = bus.wb_valid && (bus.wb_reg != 5'd0);
    mc_ok  = !reset && bus.mc_valid && !wb_eff;
    check_eq("mc_ready", bus.mc_ready, mc_ok);
    if (m_known) begin
      check_eq("pend1", bus.pend1, (bus.read_reg1 != 0) && m_pend[bus.read_reg1]);
      check_eq("pend2", bus.pend2, (bus.read_reg2 != 0) && m_pend[bus.read_reg2]);
      check_eq("rf_reg_write", bus.rf_reg_write, m_rf_we);
      check_eq("rf_write_reg", bus.rf_write_reg, m_rf_reg);
      check_eq("rf_write_data", bus.rf_write_data, m_rf_data);
      check_eq("stall_req", bus.stall_req, m_wait == LIMIT);
      check_eq("issue_conflict", bus.issue_conflict, m_conflict);
    end
    if (reset) begin
      m_pend = '0;
      m_clr_q.delete();
      m_rf_we = 0; m_rf_reg = 0; m_rf_data = 0;
      m_wait = 0;
      m_conflict = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      in_clr = 0;
      foreach (m_clr_q[i]) if (m_clr_q[i] == int'(bus.mc_issue_reg)) in_clr = 1;
      conf = bus.mc_issue && (bus.mc_issue_reg != 0) && (m_pend[bus.mc_issue_reg] || in_clr);
      foreach (m_clr_q[i]) m_pend[m_clr_q[i]] = 1'b0;
      m_clr_q.delete();
      if (bus.mc_issue && bus.mc_issue_reg != 0) m_pend[bus.mc_issue_reg] = 1'b1;
      if (mc_ok) m_clr_q.push_back(int'(bus.mc_reg));
      if (wb_eff) begin
        m_rf_we = 1; m_rf_reg = bus.wb_reg; m_rf_data = bus.wb_data;
      end else if (mc_ok) begin
        m_rf_we = (bus.mc_reg != 0); m_rf_reg = bus.mc_reg; m_rf_data = bus.mc_data;
      end else begin
        m_rf_we = 0;
      end
      if (bus.mc_valid && !mc_ok) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      else m_wait = 0;
      m_conflict = conf;
    end
    m_last_ready = mc_ok;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit burst;
    idle();
    reset = 1'b1;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_rf_we", bus.rf_reg_write, 0);
    check_eq("rst_rf_reg", bus.rf_write_reg, 0);
    check_eq("rst_rf_data", bus.rf_write_data, 0);
    check_eq("rst_stall", bus.stall_req, 0);
    check_eq("rst_conflict", bus.issue_conflict, 0);

    // WB only
    bus.wb_valid = 1; bus.wb_reg = 5; bus.wb_data = 32'hDEADBEEF;
    tick();
    idle();
    check_eq("t1_we", bus.rf_reg_write, 1);
    check_eq("t1_reg", bus.rf_write_reg, 5);
    check_eq("t1_data", bus.rf_write_data, 32'hDEADBEEF);

    // Collision: WB wins, MC goes next cycle
    bus.wb_valid = 1; bus.wb_reg = 3; bus.wb_data = 32'h3333;
    bus.mc_valid = 1; bus.mc_reg = 7; bus.mc_data = 32'h7777;
    #1 check_eq("t2_ready_blocked", bus.mc_ready, 0);
    tick();
    check_eq("t2_wb_reg", bus.rf_write_reg, 3);
    bus.wb_valid = 0;
    #1 check_eq("t2_ready_free", bus.mc_ready, 1);
    tick();
    bus.mc_valid = 0;
    check_eq("t2_mc_we", bus.rf_reg_write, 1);
    check_eq("t2_mc_reg", bus.rf_write_reg, 7);
    check_eq("t2_mc_data", bus.rf_write_data, 32'h7777);

    // Scoreboard set/clear timing and set-wins
    bus.read_reg1 = 9;
    bus.mc_issue = 1; bus.mc_issue_reg = 9;
    tick();
    bus.mc_issue = 0;
    #1 check_eq("t3_pend_set", bus.pend1, 1);
    bus.mc_valid = 1; bus.mc_reg = 9; bus.mc_data = 32'h99;
    tick();
    bus.mc_valid = 0;
    #1 check_eq("t3_pend_n1", bus.pend1, 1);
    tick();
    #1 check_eq("t3_pend_n2", bus.pend1, 0);
    bus.mc_issue = 1; bus.mc_issue_reg = 9;
    tick();
    bus.mc_issue = 0;
    bus.mc_valid = 1; bus.mc_reg = 9; bus.mc_data = 32'h98;
    tick();
    bus.mc_valid = 0;
    bus.mc_issue = 1; bus.mc_issue_reg = 9;
    tick();
    bus.mc_issue = 0;
    #1 check_eq("t3_set_wins", bus.pend1, 1);
    check_eq("t3_conflict", bus.issue_conflict, 1);
    tick();
    check_eq("t3_conflict_pulse", bus.issue_conflict, 0);
    bus.mc_valid = 1; bus.mc_reg = 9;
    tick();
    bus.mc_valid = 0;
    tick();
    tick();

    // Starvation
    bus.wb_valid = 1; bus.wb_reg = 1; bus.wb_data = 32'h1;
    bus.mc_valid = 1; bus.mc_reg = 8; bus.mc_data = 32'h88;
    repeat (3) tick();
    check_eq("t4_stall_early", bus.stall_req, 0);
    tick();
    check_eq("t4_stall_on", bus.stall_req, 1);
    tick();
    check_eq("t4_stall_hold", bus.stall_req, 1);
    bus.wb_valid = 0;
    #1 check_eq("t4_ready", bus.mc_ready, 1);
    tick();
    bus.mc_valid = 0;
    check_eq("t4_stall_off", bus.stall_req, 0);
    check_eq("t4_reg", bus.rf_write_reg, 8);

    // Register 0 handling
    bus.wb_valid = 1; bus.wb_reg = 0; bus.wb_data = 32'hBAD;
    bus.mc_valid = 1; bus.mc_reg = 4; bus.mc_data = 32'h44;
    #1 check_eq("t5_ready_wb0", bus.mc_ready, 1);
    tick();
    check_eq("t5_we4", bus.rf_reg_write, 1);
    check_eq("t5_reg4", bus.rf_write_reg, 4);
    bus.wb_valid = 0;
    bus.mc_reg = 0; bus.mc_data = 32'h55;
    bus.mc_issue = 1; bus.mc_issue_reg = 0;
    bus.read_reg1 = 0; bus.read_reg2 = 0;
    #1 check_eq("t5_ready_r0", bus.mc_ready, 1);
    tick();
    idle();
    check_eq("t5_we_r0", bus.rf_reg_write, 0);
    check_eq("t5_pend_r0", bus.pend1, 0);

    // Double issue, then reset mid-operation
    bus.read_reg1 = 12; bus.read_reg2 = 13;
    bus.mc_issue = 1; bus.mc_issue_reg = 12;
    tick();
    bus.mc_valid = 1; bus.mc_reg = 5; bus.mc_data = 32'h5;
    tick();
    bus.mc_issue = 0;
    check_eq("t6_conflict", bus.issue_conflict, 1);
    check_eq("t6_we_inflight", bus.rf_reg_write, 1);
    check_eq("t6_pend12", bus.pend1, 1);
    reset = 1;
    bus.mc_valid = 1; bus.mc_reg = 7;
    bus.mc_issue = 1; bus.mc_issue_reg = 13;
    #1 check_eq("t6_ready_in_reset", bus.mc_ready, 0);
    tick();
    reset = 0;
    bus.mc_valid = 0; bus.mc_issue = 0;
    check_eq("t6_we", bus.rf_reg_write, 0);
    check_eq("t6_reg", bus.rf_write_reg, 0);
    check_eq("t6_data", bus.rf_write_data, 0);
    check_eq("t6_stall", bus.stall_req, 0);
    check_eq("t6_conflict_clr", bus.issue_conflict, 0);
    check_eq("t6_pend12_clr", bus.pend1, 0);
    check_eq("t6_pend13_none", bus.pend2, 0);
    idle();
    tick();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      burst = ((cyc / 64) % 2) == 1;
      reset = ($urandom_range(0, 79) == 0);
      bus.wb_valid = ($urandom_range(0, 99) < (burst ? 92 : 45));
      bus.wb_reg   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.wb_data  = $urandom;
      if (!(bus.mc_valid && !m_last_ready)) begin
        bus.mc_valid = ($urandom_range(0, 99) < 50);
        bus.mc_reg   = 5'($urandom_range(0, 15));
        bus.mc_data  = $urandom;
      end
      bus.mc_issue     = ($urandom_range(0, 99) < 30);
      bus.mc_issue_reg = 5'($urandom_range(0, 15));
      bus.read_reg1    = 5'($urandom_range(0, 15));
      bus.read_reg2    = 5'($urandom_range(0, 15));
      tick();
    end
    reset = 0;
    idle();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
